rwt_axis_pkt_checker: RTL and testbench

Synthesizable AXI-Stream slave that sits at the end of a datapath under test, on-chip or in a bench. It consumes packets with a programmable ready-throttle, checks each beat against an incrementing pattern that restarts at a seed on every packet, and checks packet length. It exposes packet, beat and error counters, so hardware loopback and regression benches need no file sink.

---
 rtl/rwt_axis_chk_pkg.sv | 14 +
 rtl/rwt_sat_counter.sv | 28 ++
 rtl/rwt_axis_pkt_checker.sv | 188 ++++++++++++++++++
 tb/tb_rwt_axis_pkt_checker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rwt_axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream packet checker.
package rwt_axis_chk_pkg;

  // Saturating error counter width.
  localparam int unsigned ERR_CNT_W = 16;

  // Ready-throttle FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GAP   = 2'd2
  } chk_state_t;

endpackage : rwt_axis_chk_pkg

// File: rtl/rwt_sat_counter.sv
// Parameterised counter with synchronous clear and a saturate/wrap select.
module rwt_sat_counter #(
  parameter int unsigned W   = 16,
  parameter bit          SAT = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Clear wins over increment; saturating variants hold at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      if (!(SAT && (count == MAX_VAL))) begin
        count <= count + W'(1);
      end
    end
  end

endmodule : rwt_sat_counter

// File: rtl/rwt_axis_pkt_checker.sv
// AXI-Stream sink that throttles ready, checks an incrementing data pattern
// seeded per packet, checks packet length and keeps statistics counters.
module rwt_axis_pkt_checker
  import rwt_axis_chk_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned UWIDTH = 1,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned THR_W  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 s_axis_ready,
  input  logic                 s_axis_valid,
  input  logic [DWIDTH-1:0]    s_axis_data,
  input  logic [UWIDTH-1:0]    s_axis_user,
  input  logic                 s_axis_last,
  input  logic                 cfg_enable,
  input  logic [THR_W-1:0]     cfg_throttle,
  input  logic [CNT_W-1:0]     cfg_expected_len,
  input  logic [DWIDTH-1:0]    cfg_seed,
  input  logic                 clear,
  output logic [31:0]          pkt_count,
  output logic [31:0]          beat_count,
  output logic [ERR_CNT_W-1:0] data_err_count,
  output logic [ERR_CNT_W-1:0] len_err_count,
  output logic [CNT_W-1:0]     last_pkt_len,
  output logic [UWIDTH-1:0]    first_user,
  output logic                 err_pulse
);

  localparam logic [CNT_W-1:0] IDX_MAX = '1;

  chk_state_t        state_q;
  chk_state_t        state_d;
  logic [THR_W-1:0]  gap_q;
  logic [THR_W-1:0]  gap_d;
  logic              ready_d;

  logic [CNT_W-1:0]  idx;
  logic [DWIDTH-1:0] exp_q;

  logic              hs;
  logic              hs_last;
  logic              first_beat;
  logic [DWIDTH-1:0] exp_data;
  logic [CNT_W-1:0]  len_now;
  logic              data_err;
  logic              len_err;

  // Beat classification and pattern/length comparisons for the current cycle.
  always_comb begin
    hs         = s_axis_valid & s_axis_ready;
    hs_last    = hs & s_axis_last;
    first_beat = (idx == '0);
    exp_data   = first_beat ? cfg_seed : exp_q;
    len_now    = (idx == IDX_MAX) ? idx : (idx + CNT_W'(1));
    data_err   = hs & (s_axis_data != exp_data);
    len_err    = hs_last & (cfg_expected_len != '0) & (len_now != cfg_expected_len);
  end

  // FSM state, gap counter and registered ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      s_axis_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      s_axis_ready <= ready_d;
    end
  end

  // Next-state logic; ready is derived from the next state so it stays a flop.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d = READY;
        end
      end
      READY: begin
        if (hs) begin
          if (cfg_throttle != '0) begin
            state_d = GAP;
            gap_d   = cfg_throttle;
          end else if (!cfg_enable) begin
            state_d = IDLE;
          end
        end else if (!cfg_enable) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q <= THR_W'(1)) begin
          gap_d   = '0;
          state_d = cfg_enable ? READY : IDLE;
        end else begin
          gap_d = gap_q - THR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
    ready_d = (state_d == READY);
  end

  // Expected-data tracker advances from the expected value, not the received one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q <= '0;
    end else if (hs && !clear) begin
      exp_q <= exp_data + DWIDTH'(1);
    end
  end

  // Per-packet capture registers and the error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_pkt_len <= '0;
      first_user   <= '0;
      err_pulse    <= 1'b0;
    end else if (clear) begin
      last_pkt_len <= '0;
      first_user   <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= data_err | len_err;
      if (hs_last) begin
        last_pkt_len <= len_now;
      end
      if (hs && first_beat) begin
        first_user <= s_axis_user;
      end
    end
  end

  // In-packet beat index: restarts after a last beat, saturates otherwise.
  rwt_sat_counter #(.W(CNT_W), .SAT(1'b1)) u_idx (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear | hs_last),
    .inc    (hs),
    .count  (idx)
  );

  // Completed packets, wrapping.
  rwt_sat_counter #(.W(32), .SAT(1'b0)) u_pkt_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .inc    (hs_last),
    .count  (pkt_count)
  );

  // Accepted beats, wrapping.
  rwt_sat_counter #(.W(32), .SAT(1'b0)) u_beat_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .inc    (hs),
    .count  (beat_count)
  );

  // Data mismatches, saturating.
  rwt_sat_counter #(.W(ERR_CNT_W), .SAT(1'b1)) u_data_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .inc    (data_err),
    .count  (data_err_count)
  );

  // Length mismatches, saturating.
  rwt_sat_counter #(.W(ERR_CNT_W), .SAT(1'b1)) u_len_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .inc    (len_err),
    .count  (len_err_count)
  );

endmodule : rwt_axis_pkt_checker

// File: tb/tb_rwt_axis_pkt_checker.sv
// Self-checking bench for rwt_axis_pkt_checker: directed scenarios plus
// randomized packets against a behavioural model of the checker's rules.
module tb_rwt_axis_pkt_checker;

  logic        clk;
  logic        resetn;
  logic        s_axis_ready;
  logic        s_axis_valid;
  logic [31:0] s_axis_data;
  logic [0:0]  s_axis_user;
  logic        s_axis_last;
  logic        cfg_enable;
  logic [7:0]  cfg_throttle;
  logic [15:0] cfg_expected_len;
  logic [31:0] cfg_seed;
  logic        clear;
  logic [31:0] pkt_count;
  logic [31:0] beat_count;
  logic [15:0] data_err_count;
  logic [15:0] len_err_count;
  logic [15:0] last_pkt_len;
  logic [0:0]  first_user;
  logic        err_pulse;

  rwt_axis_pkt_checker #(
    .DWIDTH (32),
    .UWIDTH (1),
    .CNT_W  (16),
    .THR_W  (8)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .s_axis_ready     (s_axis_ready),
    .s_axis_valid     (s_axis_valid),
    .s_axis_data      (s_axis_data),
    .s_axis_user      (s_axis_user),
    .s_axis_last      (s_axis_last),
    .cfg_enable       (cfg_enable),
    .cfg_throttle     (cfg_throttle),
    .cfg_expected_len (cfg_expected_len),
    .cfg_seed         (cfg_seed),
    .clear            (clear),
    .pkt_count        (pkt_count),
    .beat_count       (beat_count),
    .data_err_count   (data_err_count),
    .len_err_count    (len_err_count),
    .last_pkt_len     (last_pkt_len),
    .first_user       (first_user),
    .err_pulse        (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int unsigned pulse_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resetn && err_pulse) pulse_seen <= pulse_seen + 1;

  // Behavioural model state: statistics plus position within the current packet.
  int unsigned m_pkt, m_beat, m_derr, m_lerr, m_last_len, m_n, m_pulses;
  logic [31:0] m_seed;
  logic [0:0]  m_first_user;
  bit          m_pulse_exp;
  int          hs_cycle;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    m_pkt = 0; m_beat = 0; m_derr = 0; m_lerr = 0;
    m_last_len = 0; m_n = 0; m_first_user = '0; m_pulse_exp = 0;
  endtask

  // One accepted beat as the checker's rules describe it.
  task automatic model_accept(input logic [31:0] d, input logic l, input logic [0:0] u, input bit clr);
    logic [31:0] expd;
    int unsigned len;
    bit e;
    if (clr) begin
      model_clear();
      return;
    end
    if (m_n == 0) begin
      m_seed = cfg_seed;
      m_first_user = u;
    end
    expd = m_seed + 32'(m_n);
    e = 0;
    m_beat++;
    if (d != expd) begin
      if (m_derr < 65535) m_derr++;
      e = 1;
    end
    if (l) begin
      len = (m_n + 1 > 65535) ? 65535 : m_n + 1;
      m_last_len = len;
      m_pkt++;
      if (cfg_expected_len != 0 && len != 32'(cfg_expected_len)) begin
        if (m_lerr < 65535) m_lerr++;
        e = 1;
      end
      m_n = 0;
    end else begin
      m_n++;
    end
    m_pulse_exp = e;
    if (e) m_pulses++;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ":pkt"},   pkt_count,      m_pkt);
    check_eq({tag, ":beat"},  beat_count,     m_beat);
    check_eq({tag, ":derr"},  32'(data_err_count), m_derr);
    check_eq({tag, ":lerr"},  32'(len_err_count),  m_lerr);
    check_eq({tag, ":lastlen"}, 32'(last_pkt_len), m_last_len);
    check_eq({tag, ":fuser"}, 32'(first_user), 32'(m_first_user));
  endtask

  // Present a beat, wait (bounded) for acceptance, return at posedge+1.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic [0:0] u,
                           input bit do_clear, input bit drop_en);
    bit got;
    got = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_user  = u;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (s_axis_ready) begin
        if (do_clear) clear = 1'b1;
        if (drop_en) cfg_enable = 1'b0;
        model_accept(d, l, u, do_clear);
        hs_cycle = cyc;
        got = 1;
      end
    end
    if (!got) begin
      check_eq("hs_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      clear = 1'b0;
      check_eq("err_pulse", 32'(err_pulse), 32'(m_pulse_exp));
    end
  endtask

  task automatic pulse_clear();
    s_axis_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic send_pkt(input logic [31:0] base, input int len);
    for (int b = 0; b < len; b++) send_beat(base + 32'(b), b == len - 1, 1'(b), 0, 0);
  endtask

  int first_hs, prev_hs, plen;
  logic [31:0] d;

  initial begin
    resetn = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0; s_axis_user = '0; s_axis_last = 1'b0;
    cfg_enable = 1'b0; cfg_throttle = '0; cfg_expected_len = '0; cfg_seed = '0; clear = 1'b0;
    m_pulses = 0; m_seed = '0; hs_cycle = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_ready", 32'(s_axis_ready), 32'd0);
    check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
    compare_all("rst");

    // 1: continuous 4-beat packets, no throttle.
    cfg_seed = 32'h100; cfg_expected_len = 16'd4; cfg_throttle = 8'd0;
    cfg_enable = 1'b1;
    @(posedge clk); #1;
    check_eq("t1_ready_after_en", 32'(s_axis_ready), 32'd1);
    first_hs = -1;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) begin
        send_beat(32'h100 + 32'(b), b == 3, 1'(p), 0, 0);
        if (first_hs < 0) first_hs = hs_cycle;
      end
    s_axis_valid = 1'b0;
    check_eq("t1_continuous", 32'(hs_cycle - first_hs), 32'd11);
    compare_all("t1");
    check_eq("t1_pkt_const", pkt_count, 32'd3);
    check_eq("t1_beat_const", beat_count, 32'd12);
    check_eq("t1_len_const", 32'(last_pkt_len), 32'd4);

    // 2: throttle 2 spaces handshakes three cycles apart.
    cfg_throttle = 8'd2;
    for (int b = 0; b < 4; b++) begin
      send_beat(32'h100 + 32'(b), b == 3, 1'b0, 0, 0);
      if (b == 0) check_eq("t2_ready_low", 32'(s_axis_ready), 32'd0);
      if (b > 0) check_eq("t2_gap", 32'(hs_cycle - prev_hs), 32'd3);
      prev_hs = hs_cycle;
    end
    s_axis_valid = 1'b0;
    compare_all("t2");
    cfg_throttle = 8'd0;
    repeat (4) @(posedge clk); #1;

    // 3: one corrupted beat costs exactly one error and one pulse.
    pulse_clear();
    pulse_seen = 0; m_pulses = 0;
    send_beat(32'h100, 0, 1'b1, 0, 0);
    send_beat(32'h1FF, 0, 1'b0, 0, 0);
    send_beat(32'h102, 0, 1'b0, 0, 0);
    send_beat(32'h103, 1, 1'b0, 0, 0);
    s_axis_valid = 1'b0;
    @(posedge clk); #1;
    compare_all("t3");
    check_eq("t3_derr_const", 32'(data_err_count), 32'd1);
    check_eq("t3_pulses", pulse_seen, 32'd1);

    // 4: length errors, then length check disabled.
    pulse_clear();
    send_pkt(32'h100, 3);
    send_pkt(32'h100, 5);
    s_axis_valid = 1'b0;
    compare_all("t4a");
    check_eq("t4_lerr_const", 32'(len_err_count), 32'd2);
    check_eq("t4_len_const", 32'(last_pkt_len), 32'd5);
    cfg_expected_len = 16'd0;
    pulse_clear();
    send_pkt(32'h100, 3);
    send_pkt(32'h100, 5);
    s_axis_valid = 1'b0;
    compare_all("t4b");
    check_eq("t4_nolen_const", 32'(len_err_count), 32'd0);
    cfg_expected_len = 16'd4;

    // 5: clear on the handshake of beat 2 restarts the packet.
    pulse_clear();
    send_beat(32'h100, 0, 1'b0, 0, 0);
    send_beat(32'h101, 0, 1'b0, 1, 0);
    compare_all("t5_clr");
    check_eq("t5_beat_zero", beat_count, 32'd0);
    send_beat(32'h102, 0, 1'b1, 0, 0);
    send_beat(32'h101, 1, 1'b0, 0, 0);
    s_axis_valid = 1'b0;
    compare_all("t5");
    check_eq("t5_len_const", 32'(last_pkt_len), 32'd2);
    check_eq("t5_derr_const", 32'(data_err_count), 32'd1);

    // 6: enable dropped on a handshake, then reset mid-packet.
    pulse_clear();
    send_beat(32'h100, 0, 1'b0, 0, 1);
    s_axis_valid = 1'b0;
    check_eq("t6_ready_drop", 32'(s_axis_ready), 32'd0);
    compare_all("t6_drop");
    cfg_enable = 1'b1;
    send_beat(32'h101, 0, 1'b0, 0, 0);
    s_axis_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(s_axis_ready), 32'd0);
    check_eq("t6_rst_beat", beat_count, 32'd0);
    model_clear();
    compare_all("t6_rst");
    @(negedge clk);
    resetn = 1'b1;
    send_pkt(32'h100, 4);
    s_axis_valid = 1'b0;
    compare_all("t6_after");

    // Randomized packets, throttle, length targets, gaps and corruption.
    for (int p = 0; p < 40; p++) begin
      cfg_throttle     = 8'($urandom_range(0, 3));
      cfg_expected_len = 16'($urandom_range(0, 6));
      cfg_seed         = $urandom;
      plen             = int'($urandom_range(1, 6));
      for (int b = 0; b < plen; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_axis_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        d = cfg_seed + 32'(b);
        if ($urandom_range(0, 7) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
        send_beat(d, b == plen - 1, 1'($urandom), 0, 0);
      end
      s_axis_valid = 1'b0;
      compare_all("rnd");
    end
    @(posedge clk); #1;
    check_eq("pulse_total", pulse_seen, m_pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rwt_axis_pkt_checker
